// File: rtl/sgd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sgd_pkg
// Brief    : Shared types and helpers for the SGD model write-back collector.
// Revision : 1.0
// ============================================================================
package sgd_pkg;

  localparam int ENGINE_NUM_DEF = 8;
  localparam int DATA_W_DEF     = 512;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_EPOCH_WAIT = 5'b00010,
    ST_STREAM     = 5'b00100,
    ST_DRAIN      = 5'b01000,
    ST_DONE       = 5'b10000
  } state_t;

  function automatic logic [31:0] bytes_per_beat(input int data_w);
    return 32'(data_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgd_wb_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sgd_wb_read_pipe
// Brief    : Read-tag delay line aligned to FIFO latency, plus output mux/register.
// Revision : 1.0
// ============================================================================
module sgd_wb_read_pipe
  import sgd_pkg::*;
#(
  parameter int ENGINE_NUM = ENGINE_NUM_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int E_W        = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rd_valid,
  input  logic [E_W-1:0]                      rd_engine,
  input  logic [ENGINE_NUM-1:0][DATA_W-1:0]   fifo_rd_data,
  output logic [DATA_W-1:0]                   data_out,
  output logic                                data_out_valid
);

  logic [RD_LAT-1:0]          r_vld;
  logic [RD_LAT-1:0][E_W-1:0] r_eng;

  // The last tag stage lines up with the cycle in which fifo_rd_data is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld          <= '0;
      r_eng          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      r_vld[0] <= rd_valid;
      r_eng[0] <= rd_engine;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_eng[i] <= r_eng[i-1];
      end
      data_out_valid <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) begin
        data_out <= fifo_rd_data[r_eng[RD_LAT-1]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sgd_model_writeback_collector.sv
`default_nettype none
// ============================================================================
// Module   : sgd_model_writeback_collector
// Brief    : Drains per-engine model FIFOs round-robin each epoch into write DMA.
// Revision : 1.0
// ============================================================================
module sgd_model_writeback_collector
  import sgd_pkg::*;
#(
  parameter int ENGINE_NUM       = ENGINE_NUM_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int BEATS_PER_ENGINE = 4,
  parameter int DIM_PER_ROUND    = 512,
  parameter int RD_LAT           = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              started,
  input  logic [63:0]                       addr_model,
  input  logic [31:0]                       dimension,
  input  logic [31:0]                       num_epochs,
  input  logic [ENGINE_NUM-1:0][DATA_W-1:0] fifo_rd_data,
  output logic [ENGINE_NUM-1:0]             fifo_rd_en,
  input  logic [ENGINE_NUM-1:0]             fifo_empty,
  output logic                              cmd_start,
  output logic [63:0]                       cmd_addr,
  output logic [31:0]                       cmd_length,
  output logic [DATA_W-1:0]                 data_out,
  output logic                              data_out_valid,
  input  logic                              data_out_almost_full,
  output logic [31:0]                       epoch_count,
  output logic                              done,
  output logic                              error
);

  localparam int          E_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int          B_W = (BEATS_PER_ENGINE > 1) ? $clog2(BEATS_PER_ENGINE) : 1;
  localparam logic [31:0] c_dim_per_round   = 32'(DIM_PER_ROUND);
  localparam logic [31:0] c_bytes_per_round =
      32'(ENGINE_NUM * BEATS_PER_ENGINE) * bytes_per_beat(DATA_W);

  state_t      r_state;
  logic        r_started_s1, r_started_s2, r_started_s3;
  logic        r_af;
  logic [31:0] r_rounds, r_num_epochs, r_round;
  logic [63:0] r_next_addr;
  logic [E_W-1:0] r_eng;
  logic [B_W-1:0] r_beat;
  logic [3:0]  r_outstanding;

  logic        w_start_rise, w_rd, w_last;
  logic [31:0] w_rounds;

  assign w_start_rise = r_started_s2 & ~r_started_s3;
  assign w_rounds     = (dimension / c_dim_per_round) +
                        {31'd0, (dimension % c_dim_per_round) != 32'd0};
  // No skipping: an empty engine stalls the whole stream until it refills.
  assign w_rd   = (r_state == ST_STREAM) && !fifo_empty[r_eng] && !r_af;
  assign w_last = (r_round == r_rounds - 32'd1) &&
                  (r_eng == E_W'(ENGINE_NUM - 1)) &&
                  (r_beat == B_W'(BEATS_PER_ENGINE - 1));

  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      fifo_rd_en[i] = w_rd && (r_eng == E_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_started_s1  <= 1'b0;
      r_started_s2  <= 1'b0;
      r_started_s3  <= 1'b0;
      r_af          <= 1'b0;
      r_rounds      <= '0;
      r_num_epochs  <= '0;
      r_round       <= '0;
      r_next_addr   <= '0;
      r_eng         <= '0;
      r_beat        <= '0;
      r_outstanding <= '0;
      cmd_start     <= 1'b0;
      cmd_addr      <= '0;
      cmd_length    <= '0;
      epoch_count   <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      r_started_s1 <= started;
      r_started_s2 <= r_started_s1;
      r_started_s3 <= r_started_s2;
      r_af         <= data_out_almost_full;
      cmd_start    <= 1'b0;

      case ({w_rd, data_out_valid})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            if (dimension == 32'd0 || num_epochs == 32'd0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              error   <= 1'b1;
            end else begin
              r_state      <= ST_EPOCH_WAIT;
              r_rounds     <= w_rounds;
              r_num_epochs <= num_epochs;
              r_next_addr  <= addr_model;
              cmd_length   <= w_rounds * c_bytes_per_round;
              epoch_count  <= '0;
            end
          end
        end
        ST_EPOCH_WAIT: begin
          if (!fifo_empty[0]) begin
            // Running address equals addr_model + epoch_count * cmd_length.
            cmd_start   <= 1'b1;
            cmd_addr    <= r_next_addr;
            r_next_addr <= r_next_addr + {32'd0, cmd_length};
            r_round     <= '0;
            r_eng       <= '0;
            r_beat      <= '0;
            r_state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_rd) begin
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
            if (r_beat == B_W'(BEATS_PER_ENGINE - 1)) begin
              r_beat <= '0;
              if (r_eng == E_W'(ENGINE_NUM - 1)) begin
                r_eng   <= '0;
                r_round <= r_round + 32'd1;
              end else begin
                r_eng <= r_eng + E_W'(1);
              end
            end else begin
              r_beat <= r_beat + B_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_outstanding == 4'd0) begin
            epoch_count <= epoch_count + 32'd1;
            if (epoch_count + 32'd1 == r_num_epochs) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_EPOCH_WAIT;
            end
          end
        end
        ST_DONE: begin
          if (!r_started_s2) begin
            r_state <= ST_IDLE;
            done    <= 1'b0;
            error   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sgd_wb_read_pipe #(
    .ENGINE_NUM (ENGINE_NUM),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .E_W        (E_W)
  ) u_read_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_valid       (w_rd),
    .rd_engine      (r_eng),
    .fifo_rd_data   (fifo_rd_data),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_sgd_model_writeback_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgd_model_writeback_collector
// Brief    : Scoreboard bench for the model write-back collector.
// Revision : 1.0
// ============================================================================
module tb_sgd_model_writeback_collector;
  import sgd_pkg::*;

  localparam int EN = 2, DW = 512, BPE = 4, DPR = 512, RDL = 1;
  localparam int BYTES = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic started = 1'b0;
  logic [63:0] addr_model = '0;
  logic [31:0] dimension = '0;
  logic [31:0] num_epochs = '0;
  logic [EN-1:0][DW-1:0] fifo_rd_data;
  logic [EN-1:0] fifo_rd_en;
  logic [EN-1:0] fifo_empty = '0;
  logic cmd_start;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_length;
  logic [DW-1:0] data_out;
  logic data_out_valid;
  logic data_out_almost_full = 1'b0;
  logic [31:0] epoch_count;
  logic done, error;

  sgd_model_writeback_collector #(
    .ENGINE_NUM(EN), .DATA_W(DW), .BEATS_PER_ENGINE(BPE),
    .DIM_PER_ROUND(DPR), .RD_LAT(RDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .started(started), .addr_model(addr_model),
    .dimension(dimension), .num_epochs(num_epochs), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .cmd_start(cmd_start),
    .cmd_addr(cmd_addr), .cmd_length(cmd_length), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_almost_full(data_out_almost_full),
    .epoch_count(epoch_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_beats = 0, n_cmds = 0, n_rd = 0, empty_viol = 0;
  int cyc = 0, first_beat = -1, last_beat = -1;
  int af_cnt = 0, af_max = 0;
  logic af_prev = 1'b0;
  logic bp_on = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [95:0]   cmd_q[$];
  logic [23:0]   fifo_seq[EN] = '{default: '0};
  logic [23:0]   exp_seq[EN]  = '{default: '0};

  function automatic logic [DW-1:0] make_beat(input int e, input logic [23:0] s);
    logic [31:0] w;
    w = {8'(e), s};
    return {(DW/32){w}};
  endfunction

  // Engine FIFO model with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < EN; i++) begin
      if (fifo_rd_en[i]) begin
        fifo_rd_data[i] <= make_beat(i, fifo_seq[i]);
        fifo_seq[i]     <= fifo_seq[i] + 24'd1;
      end
    end
  end

  // Output monitor: pops the scoreboard queues.
  always @(negedge clk) begin
    logic [DW-1:0] eb;
    logic [95:0]   ec;
    cyc++;
    if (data_out_valid) begin
      n_beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h, required no beat", data_out[31:0]);
      end else begin
        eb = exp_q.pop_front();
        if (data_out !== eb) begin
          n_fail++;
          $display("FAIL beat_data: got %h, required %h", data_out[31:0], eb[31:0]);
        end
      end
    end
    if (cmd_start) begin
      n_cmds++;
      n_checks++;
      if (cmd_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got addr %h len %0d, required no command", cmd_addr, cmd_length);
      end else begin
        ec = cmd_q.pop_front();
        if (cmd_addr !== ec[95:32] || cmd_length !== ec[31:0]) begin
          n_fail++;
          $display("FAIL cmd_fields: got addr %h len %0d, required addr %h len %0d",
                   cmd_addr, cmd_length, ec[95:32], ec[31:0]);
        end
      end
    end
    for (int i = 0; i < EN; i++) begin
      if (fifo_rd_en[i]) begin
        n_rd++;
        if (fifo_empty[i]) empty_viol++;
      end
    end
    if (data_out_almost_full) begin
      if (!af_prev) af_cnt = 0;
      if (data_out_valid) af_cnt++;
      if (af_cnt > af_max) af_max = af_cnt;
    end
    af_prev = data_out_almost_full;
  end

  task automatic push_run(input logic [31:0] dim, input logic [31:0] ep, input logic [63:0] base);
    logic [31:0] rounds, len;
    rounds = dim / DPR + ((dim % DPR) != 0 ? 1 : 0);
    len    = rounds * EN * BPE * BYTES;
    for (int k = 0; k < int'(ep); k++) begin
      cmd_q.push_back({base + 64'(k) * 64'(len), len});
      for (int r = 0; r < int'(rounds); r++)
        for (int e = 0; e < EN; e++)
          for (int b = 0; b < BPE; b++) begin
            exp_q.push_back(make_beat(e, exp_seq[e]));
            exp_seq[e] = exp_seq[e] + 24'd1;
          end
    end
  endtask

  task automatic start_run(input logic [31:0] dim, input logic [31:0] ep, input logic [63:0] base);
    @(negedge clk);
    dimension = dim; num_epochs = ep; addr_model = base;
    push_run(dim, ep, base);
    n_beats = 0; first_beat = -1; last_beat = -1;
    started = 1'b1;
  endtask

  task automatic finish_run(input string name, input int ep, input int beats);
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s_done_timeout: done=%b, required 1", name, done);
    end
    n_checks++;
    if (epoch_count !== 32'(ep) || error !== 1'b0) begin
      n_fail++; $display("FAIL %s_epoch_count: got %0d err %b, required %0d err 0", name, epoch_count, error, ep);
    end
    n_checks++;
    if (n_beats != beats || exp_q.size() != 0 || cmd_q.size() != 0) begin
      n_fail++; $display("FAIL %s_beat_count: got %0d beats (%0d left), required %0d", name, n_beats, exp_q.size(), beats);
    end
    started = 1'b0;
    k = 0;
    while (done !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_clear: done=%b, required 0", name, done);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (fifo_rd_en !== '0 || cmd_start !== 1'b0 || cmd_addr !== '0 || cmd_length !== '0 ||
        data_out !== '0 || data_out_valid !== 1'b0 || epoch_count !== '0 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rd_en=%b cs=%b addr=%h len=%0d dv=%b d=%h ep=%0d done=%b err=%b, required all 0",
               name, fifo_rd_en, cmd_start, cmd_addr, cmd_length, data_out_valid, data_out[31:0],
               epoch_count, done, error);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_values");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    start_run(32'd1024, 32'd1, 64'h0000_0001_0000_0000);
    finish_run("basic", 1, 16);
    n_checks++;
    if (last_beat - first_beat != 15) begin
      n_fail++; $display("FAIL basic_back_to_back: span %0d cycles, required 15", last_beat - first_beat);
    end
  endtask

  task automatic test_multi_epoch();
    start_run(32'd512, 32'd3, 64'h0000_0000_8000_0000);
    finish_run("multi_epoch", 3, 24);
  endtask

  task automatic test_empty_stall();
    int k = 0, seen = 0, viol = 0;
    start_run(32'd1024, 32'd1, 64'h0000_0000_0000_4000);
    while (seen < 2 && k < 200) begin
      @(negedge clk); k++;
      if (fifo_rd_en[1]) seen++;
    end
    n_checks++;
    if (seen < 2) begin
      n_fail++; $display("FAIL stall_reach_e1: saw %0d E1 reads, required 2", seen);
    end
    @(posedge clk); #1 fifo_empty[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== '0) viol++;
    end
    n_checks++;
    if (viol != 0) begin
      n_fail++; $display("FAIL stall_no_read: %0d cycles with reads, required 0", viol);
    end
    @(posedge clk); #1 fifo_empty[1] = 1'b0;
    finish_run("stall", 1, 16);
  endtask

  task automatic test_backpressure();
    af_max = 0;
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk); #1 data_out_almost_full = ($urandom_range(0, 99) < 30);
        end
        data_out_almost_full = 1'b0;
      end
    join_none
    start_run(32'd2048, 32'd2, 64'h0000_0000_0010_0000);
    finish_run("backpressure", 2, 64);
    bp_on = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (af_max > RDL + 3) begin
      n_fail++; $display("FAIL bp_slack: %0d beats after almost_full, required <= %0d", af_max, RDL + 3);
    end
  endtask

  task automatic test_zero_param(input logic [31:0] dim, input logic [31:0] ep, input string name);
    int rd0, cmd0, k;
    rd0 = n_rd; cmd0 = n_cmds;
    @(negedge clk);
    dimension = dim; num_epochs = ep; started = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 4) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      n_fail++; $display("FAIL %s_done_error: done=%b error=%b, required 1 1", name, done, error);
    end
    @(negedge clk) started = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (n_rd != rd0 || n_cmds != cmd0) begin
      n_fail++; $display("FAIL %s_no_activity: reads %0d cmds %0d, required 0 0", name, n_rd - rd0, n_cmds - cmd0);
    end
    n_checks++;
    if (done !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL %s_clear: done=%b error=%b, required 0 0", name, done, error);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    start_run(32'd2048, 32'd2, 64'h0000_0000_0020_0000);
    while (n_beats < 10 && k < 300) begin @(negedge clk); k++; end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1 check_reset_outputs("reset_mid_values");
    exp_q.delete();
    cmd_q.delete();
    for (int i = 0; i < EN; i++) exp_seq[i] = fifo_seq[i];
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (data_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_valid: data_out_valid=%b, required 0", data_out_valid);
      end
    end
    push_run(32'd2048, 32'd2, 64'h0000_0000_0020_0000);
    n_beats = 0;
    rst_n = 1'b1;
    finish_run("reset_restart", 2, 64);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_epoch();
    test_empty_stall();
    test_backpressure();
    test_zero_param(32'd0, 32'd1, "zero_dim");
    test_zero_param(32'd512, 32'd0, "zero_epochs");
    test_reset_mid();
    n_checks++;
    if (empty_viol != 0) begin
      n_fail++; $display("FAIL read_while_empty: %0d reads, required 0", empty_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sgd_model_writeback_collector.md
# sgd_model_writeback_collector

Parametrised collector that drains the per-engine updated-model FIFOs at the end of every epoch and streams them to the memory write interface. Each epoch it issues one write command, then reads the FIFOs round-robin, `BEATS_PER_ENGINE` beats per engine per round. Compared with the previous block, it adds:
- a generic engine count, data width, beat count and FIFO read latency;
- a per-engine empty check before every read;
- an epoch limit, with done and error reporting.

It sits between the SGD engines' x_updated FIFOs and the memory write DMA.

## Interface
Parameters:
- ENGINE_NUM, 8, number of engine FIFOs (1..16)
- DATA_W, 512, FIFO/output beat width in bits (multiple of 32)
- BEATS_PER_ENGINE, 4, consecutive beats taken from one engine per round (power of 2)
- DIM_PER_ROUND, 512, model dimensions covered by one full round over all engines
- RD_LAT, 1, FIFO read latency in cycles from rd_en to rd_data valid (1..4)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- started  in  1  level; run request
- addr_model  in  64  byte base address of model region
- dimension  in  32  model dimension (floats)
- num_epochs  in  32  epochs to write back
- fifo_rd_data  in  ENGINE_NUM x DATA_W  engine FIFO read data
- fifo_rd_en  out  ENGINE_NUM  one-hot read enable
- fifo_empty  in  ENGINE_NUM  engine FIFO empty flags
- cmd_start  out  1  one-cycle write-command pulse
- cmd_addr  out  64  write byte address
- cmd_length  out  32  write byte length
- data_out  out  DATA_W  write data beat
- data_out_valid  out  1  beat valid
- data_out_almost_full  in  1  downstream almost-full
- epoch_count  out  32  epochs completed
- done  out  1  all epochs written
- error  out  1  illegal parameters (dimension==0 or num_epochs==0)

## Operation
Parameters are latched on the IDLE→EPOCH_WAIT transition and ignored afterwards:
- rounds = ceil(dimension / DIM_PER_ROUND)
- beats_per_epoch = rounds × ENGINE_NUM × BEATS_PER_ENGINE
- cmd_length = beats_per_epoch × DATA_W/8, computed in 32-bit arithmetic; overflow is not checked.

State machine (one-hot):
- **IDLE:** `started` is registered with a 2-stage synchroniser. On a rising edge go to EPOCH_WAIT, or to DONE with `error=1` if dimension==0 or num_epochs==0.
- **EPOCH_WAIT:** when `fifo_empty[0]==0`, pulse `cmd_start` for one cycle with `cmd_addr = addr_model + epoch_count × cmd_length`, then go to STREAM.
- **STREAM:** maintain indices beat b, engine e and round r. A read is issued, with `fifo_rd_en[e]=1`, only when `!fifo_empty[e] && !af_r`, where `af_r` is `data_out_almost_full` registered once.
  - If engine e is empty, the block stalls on e. It does not skip it.
  - b wraps at BEATS_PER_ENGINE and advances e; e wraps at ENGINE_NUM and advances r.
  - The last read of the epoch (r == rounds-1, e == ENGINE_NUM-1, b == BEATS_PER_ENGINE-1) moves to DRAIN.
- **DRAIN:** wait until the outstanding-beat counter reaches 0. Then `epoch_count += 1`, and go to DONE if `epoch_count == num_epochs`, else to EPOCH_WAIT.
- **DONE:** hold `done=1` and `error`. Go to IDLE when `started` (synchronised) is 0.

Data path:
- The engine index travels with each read through an RD_LAT-deep shift register.
- The selected `fifo_rd_data` is captured, then registered again onto `data_out`.
- Exactly beats_per_epoch beats are emitted per epoch, in read order.

## Timing
- Reset values: `fifo_rd_en=0`, `cmd_start=0`, `cmd_addr=0`, `cmd_length=0`, `data_out=0`, `data_out_valid=0`, `epoch_count=0`, `done=0`, `error=0`, state IDLE.
- Reset mid-operation discards all in-flight beats; no valid beat follows reset.
- Latency from `fifo_rd_en` to `data_out_valid` is RD_LAT+1 cycles.
- `cmd_start` precedes the first `data_out_valid` of its epoch by at least 2 cycles.
- Backpressure: after `data_out_almost_full` rises, up to RD_LAT+3 more beats may appear. The downstream FIFO must reserve at least that much slack.
- `fifo_empty` and the almost-full condition both stall the read. No beat is ever dropped or duplicated.
- Throughput is 1 beat/cycle when no stall is active.
- `started` dropping during STREAM is ignored; the epoch completes.

## Structure
- Shared package `sgd_pkg`: the `ENGINE_NUM`/`DATA_W` defaults, `state_t` enum, and a `bytes_per_beat` function.
- One sub-module, `sgd_wb_read_pipe`: an RD_LAT-deep valid/engine-index delay line plus the output mux and registers.
- The FSM and counters live in the top module.

## Test plan
- ENGINE_NUM=2, BEATS=4, DIM_PER_ROUND=512, dimension=1024, num_epochs=1, FIFOs always full, almost_full=0:
  - one `cmd_start` with addr=addr_model and length=1024;
  - 16 beats in order E0×4, E1×4, E0×4, E1×4, back-to-back;
  - `done=1`, `epoch_count=1`.
- num_epochs=3, dimension=512: three commands at addr_model, +512 and +1024 (length 512 each); 8 beats each; `epoch_count` ends at 3.
- Hold `fifo_empty[1]=1` for 20 cycles mid-round: no `fifo_rd_en[1]` and no E0 reads past that round boundary; the stream resumes after release with beat order and count intact.
- Toggle almost_full randomly at 30%: no beat is lost or duplicated; at most RD_LAT+3 beats appear after each assertion.
- dimension=0: `done=1` and `error=1` within 4 cycles of `started`; no `cmd_start` and no `fifo_rd_en`.
- Assert rst_n=0 mid-STREAM: all outputs take their reset values on the next edge; with `started` still 1, a fresh run begins at epoch 0.
